// File: rtl/block_stream_pkg.sv
// Shared definitions for the block-to-pixel streamer: FSM encoding, scan modes
// and the width helper used to size pixel indices.
package block_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic MODE_RASTER = 1'b0;
  localparam logic MODE_COLUMN = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_MAX_M = 72;
  localparam int IDX_W     = clog2(DEF_MAX_M * DEF_MAX_M + 1);

endpackage

// File: rtl/block_pixel_streamer_if.sv
// Block-in / pixel-out bus of the streamer. master = streamer view, slave =
// environment view (upstream block source plus downstream pixel sink).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A source holding valid keeps its payload stable until that edge; ready may
// toggle freely and never depends combinationally on valid inside the streamer.
interface block_pixel_streamer_if #(
  parameter int DATA_DEPTH = 8,
  parameter int MAX_M      = 72,
  parameter int LANES      = 1
);
  logic [DATA_DEPTH*MAX_M*MAX_M-1:0] block_in;
  logic [6:0]                        m_size;
  logic                              mode;
  logic                              last_block;
  logic                              block_valid;
  logic                              block_ready;

  logic [LANES*DATA_DEPTH-1:0]       pix_data;
  logic [LANES-1:0]                  pix_keep;
  logic                              pix_valid;
  logic                              pix_ready;
  logic                              pix_last;
  logic                              image_done;

  modport master (
    input  block_in, m_size, mode, last_block, block_valid, pix_ready,
    output block_ready, pix_data, pix_keep, pix_valid, pix_last, image_done
  );

  modport slave (
    output block_in, m_size, mode, last_block, block_valid, pix_ready,
    input  block_ready, pix_data, pix_keep, pix_valid, pix_last, image_done
  );
endinterface

// File: rtl/pixel_index_gen.sv
// Row/column scan counters for one block; produces LANES consecutive source
// indices (r*M+c) per step in raster or column-major order.
module pixel_index_gen
  import block_stream_pkg::*;
#(
  parameter int MAX_M    = 72,
  parameter int LANES    = 1,
  parameter int IDX_BITS = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [6:0]                load_m,
  input  logic                      load_mode,
  input  logic                      advance,
  output logic [LANES*IDX_BITS-1:0] idx,
  output logic [LANES-1:0]          lane_valid,
  output logic                      last_step
);
  // Extra bits keep p + LANES from wrapping on the final step.
  localparam int PW = IDX_BITS + 3;

  logic [6:0]    m_q, r_q, c_q, r_nxt, c_nxt, rr, cc, m_top;
  logic          mode_q;
  logic [PW-1:0] p_q, total;

  always_comb begin
    total      = PW'(m_q) * PW'(m_q);
    m_top      = m_q - 7'd1;
    rr         = r_q;
    cc         = c_q;
    idx        = '0;
    lane_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      idx[l*IDX_BITS +: IDX_BITS] = IDX_BITS'(rr) * IDX_BITS'(m_q) + IDX_BITS'(cc);
      lane_valid[l] = (p_q + PW'(l)) < total;
      if (mode_q == MODE_RASTER) begin
        if (cc == m_top) begin
          cc = '0;
          rr = (rr == m_top) ? '0 : rr + 7'd1;
        end else begin
          cc = cc + 7'd1;
        end
      end else begin
        if (rr == m_top) begin
          rr = '0;
          cc = (cc == m_top) ? '0 : cc + 7'd1;
        end else begin
          rr = rr + 7'd1;
        end
      end
    end
    r_nxt     = rr;
    c_nxt     = cc;
    last_step = (p_q + PW'(LANES)) >= total;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q    <= '0;
      mode_q <= MODE_RASTER;
      r_q    <= '0;
      c_q    <= '0;
      p_q    <= '0;
    end else if (load) begin
      m_q    <= load_m;
      mode_q <= load_mode;
      r_q    <= '0;
      c_q    <= '0;
      p_q    <= '0;
    end else if (advance) begin
      r_q    <= r_nxt;
      c_q    <= c_nxt;
      p_q    <= p_q + PW'(LANES);
    end
  end

endmodule

// File: rtl/block_pixel_streamer.sv
// Registers one M x M block per handshake and streams it out as LANES-pixel
// beats under backpressure; flags image end after the last tagged block.
module block_pixel_streamer
  import block_stream_pkg::*;
#(
  parameter int DATA_DEPTH = 8,
  parameter int MAX_M      = 72,
  parameter int LANES      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  block_pixel_streamer_if.master        bus,
  output state_t                        dbg_state
);
  localparam int IDX_BITS = clog2(MAX_M * MAX_M + 1);
  localparam int BLK_W    = DATA_DEPTH * MAX_M * MAX_M;

  state_t                      state;
  logic [BLK_W-1:0]            block_q;
  logic                        last_q, block_ready_q, pix_valid_q, image_done_q;
  logic [6:0]                  m_clamped;
  logic                        accept, advance, last_step;
  logic [LANES*IDX_BITS-1:0]   idx;
  logic [LANES-1:0]            lane_valid, keep_c;
  logic [LANES*DATA_DEPTH-1:0] data_c;
  logic [IDX_BITS-1:0]         sel;

  assign m_clamped = (bus.m_size > 7'(MAX_M)) ? 7'(MAX_M) : bus.m_size;
  assign accept    = (state == IDLE) && bus.block_valid && block_ready_q;
  assign advance   = (state == STREAM) && pix_valid_q && bus.pix_ready && !last_step;

  pixel_index_gen #(
    .MAX_M    (MAX_M),
    .LANES    (LANES),
    .IDX_BITS (IDX_BITS)
  ) u_index_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_m     (m_clamped),
    .load_mode  (bus.mode),
    .advance    (advance),
    .idx        (idx),
    .lane_valid (lane_valid),
    .last_step  (last_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      block_q       <= '0;
      last_q        <= 1'b0;
      block_ready_q <= 1'b1;
      pix_valid_q   <= 1'b0;
      image_done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            block_q      <= bus.block_in;
            last_q       <= bus.last_block;
            image_done_q <= 1'b0;
            // An empty block carries no beats; only its last flag matters.
            if (m_clamped == 7'd0) begin
              image_done_q <= bus.last_block;
            end else begin
              state         <= STREAM;
              block_ready_q <= 1'b0;
              pix_valid_q   <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (bus.pix_ready && last_step) begin
            state       <= DRAIN;
            pix_valid_q <= 1'b0;
            if (last_q) image_done_q <= 1'b1;
          end
        end
        DRAIN: begin
          state         <= IDLE;
          block_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat payload is a pure function of registered state, so it holds while stalled.
  always_comb begin
    data_c = '0;
    keep_c = '0;
    sel    = '0;
    for (int l = 0; l < LANES; l++) begin
      sel = idx[l*IDX_BITS +: IDX_BITS];
      if (pix_valid_q && lane_valid[l]) begin
        data_c[l*DATA_DEPTH +: DATA_DEPTH] = block_q[int'(sel)*DATA_DEPTH +: DATA_DEPTH];
        keep_c[l] = 1'b1;
      end
    end
  end

  assign bus.block_ready = block_ready_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_data    = data_c;
  assign bus.pix_keep    = keep_c;
  assign bus.pix_last    = pix_valid_q && last_step;
  assign bus.image_done  = image_done_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_block_pixel_streamer.sv
// Directed bench for block_pixel_streamer: a 1-lane and a 2-lane instance,
// expected beats queued by the stimulus and popped by per-instance monitors.
module tb_block_pixel_streamer;
  import block_stream_pkg::*;

  localparam int DD = 8;
  localparam int MM = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  block_pixel_streamer_if #(.DATA_DEPTH(DD), .MAX_M(MM), .LANES(1)) bus1 ();
  block_pixel_streamer_if #(.DATA_DEPTH(DD), .MAX_M(MM), .LANES(2)) bus2 ();
  state_t st1, st2;

  block_pixel_streamer #(.DATA_DEPTH(DD), .MAX_M(MM), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(st1)
  );
  block_pixel_streamer #(.DATA_DEPTH(DD), .MAX_M(MM), .LANES(2)) u2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q1[$];
  logic [23:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    exp_q1.push_back({14'd0, l, 1'b1, d});
  endtask

  task automatic push2(input logic [15:0] d, input logic [1:0] k, input logic l);
    exp_q2.push_back({5'd0, l, k, d});
  endtask

  // Monitors: compare the presented beat with the queue head every cycle it is
  // valid (so a stalled beat must stay equal), pop only on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus1.pix_valid) begin
        if (exp_q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL u1_unexpected_beat: got %h expected no beat at %0t", bus1.pix_data, $time);
        end else begin
          check("u1_beat", {14'd0, bus1.pix_last, bus1.pix_keep, bus1.pix_data}, exp_q1[0]);
          if (bus1.pix_ready) void'(exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus2.pix_valid) begin
        if (exp_q2.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL u2_unexpected_beat: got %h expected no beat at %0t", bus2.pix_data, $time);
        end else begin
          check("u2_beat", {5'd0, bus2.pix_last, bus2.pix_keep, bus2.pix_data}, exp_q2[0]);
          if (bus2.pix_ready) void'(exp_q2.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pix(input int which, input int i, input logic [7:0] v);
    if (which == 1) bus1.block_in[i*8 +: 8] = v;
    else            bus2.block_in[i*8 +: 8] = v;
  endtask

  task automatic clear_block(input int which);
    if (which == 1) bus1.block_in = '0;
    else            bus2.block_in = '0;
  endtask

  // Returns one time step after the accepting edge.
  task automatic send(input int which, input logic [6:0] m, input logic md, input logic lst);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (((which == 1) ? !bus1.block_ready : !bus2.block_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL block_ready_timeout: got ready=0 for %0d cycles expected ready=1", n);
    end
    if (which == 1) begin
      bus1.m_size = m; bus1.mode = md; bus1.last_block = lst; bus1.block_valid = 1'b1;
    end else begin
      bus2.m_size = m; bus2.mode = md; bus2.last_block = lst; bus2.block_valid = 1'b1;
    end
    @(posedge clk); #1;
    // Scramble the source: the streamer must work from its own copy.
    if (which == 1) begin
      bus1.block_valid = 1'b0; bus1.block_in = {16{$urandom()}};
    end else begin
      bus2.block_valid = 1'b0; bus2.block_in = {16{$urandom()}};
    end
  endtask

  task automatic wait_drain(input int which);
    int n;
    n = 0;
    while (((which == 1) ? exp_q1.size() : exp_q2.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL drain_timeout_u%0d: got %0d beats outstanding expected 0", which,
               (which == 1) ? exp_q1.size() : exp_q2.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic load_2x2();
    clear_block(1);
    set_pix(1, 0, 8'h11); set_pix(1, 1, 8'h22); set_pix(1, 2, 8'h33); set_pix(1, 3, 8'h44);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] pat;
    bus1.block_in = '0; bus1.m_size = '0; bus1.mode = 1'b0; bus1.last_block = 1'b0;
    bus1.block_valid = 1'b0; bus1.pix_ready = 1'b1;
    bus2.block_in = '0; bus2.m_size = '0; bus2.mode = 1'b0; bus2.last_block = 1'b0;
    bus2.block_valid = 1'b0; bus2.pix_ready = 1'b1;

    #12;
    check("rst_block_ready", bus1.block_ready, 1);
    check("rst_pix_valid",   bus1.pix_valid, 0);
    check("rst_pix_keep",    bus1.pix_keep, 0);
    check("rst_pix_data",    bus1.pix_data, 0);
    check("rst_pix_last",    bus1.pix_last, 0);
    check("rst_image_done",  bus1.image_done, 0);
    check("rst_state",       st1, IDLE);
    check("rst_u2_ready",    bus2.block_ready, 1);
    check("rst_u2_valid",    bus2.pix_valid, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: raster 2x2, back-to-back beats from one cycle after accept
    load_2x2();
    push1(8'h11, 0); push1(8'h22, 0); push1(8'h33, 0); push1(8'h44, 1);
    send(1, 7'd2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_valid_each_cycle", bus1.pix_valid, 1);
      check("t1_ready_low", bus1.block_ready, 0);
    end
    @(negedge clk);
    check("t1_drain_valid", bus1.pix_valid, 0);
    check("t1_drain_ready", bus1.block_ready, 0);
    check("t1_drain_state", st1, DRAIN);
    @(negedge clk);
    check("t1_idle_ready", bus1.block_ready, 1);
    check("t1_idle_state", st1, IDLE);
    wait_drain(1);

    // 2: column-major of the same block
    load_2x2();
    push1(8'h11, 0); push1(8'h33, 0); push1(8'h22, 0); push1(8'h44, 1);
    send(1, 7'd2, 1'b1, 1'b0);
    wait_drain(1);

    // 3: two lanes, 3x3 -> partial final beat
    clear_block(2);
    for (int i = 0; i < 9; i++) set_pix(2, i, 8'(i + 1));
    push2(16'h0201, 2'b11, 0); push2(16'h0403, 2'b11, 0); push2(16'h0605, 2'b11, 0);
    push2(16'h0807, 2'b11, 0); push2(16'h0009, 2'b01, 1);
    send(2, 7'd3, 1'b0, 1'b0);
    wait_drain(2);

    // 4: backpressure holds beat 22 for three cycles
    load_2x2();
    push1(8'h11, 0); push1(8'h22, 0); push1(8'h33, 0); push1(8'h44, 1);
    send(1, 7'd2, 1'b0, 1'b0);
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      bus1.pix_ready = pat[k];
      @(posedge clk); #1;
    end
    bus1.pix_ready = 1'b1;
    wait_drain(1);

    // 5: last block -> sticky image_done, cleared by next accept
    load_2x2();
    push1(8'h11, 0); push1(8'h22, 0); push1(8'h33, 0); push1(8'h44, 1);
    send(1, 7'd2, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus1.pix_valid) begin
        check("t5_ready_low_in_stream", bus1.block_ready, 0);
        check("t5_done_low_in_stream", bus1.image_done, 0);
        if (bus1.pix_ready && bus1.pix_last) break;
      end
    end
    @(negedge clk);
    check("t5_done_rise", bus1.image_done, 1);
    check("t5_drain_valid", bus1.pix_valid, 0);
    repeat (3) @(negedge clk);
    check("t5_done_sticky", bus1.image_done, 1);
    clear_block(1);
    set_pix(1, 0, 8'h77);
    push1(8'h77, 1);
    send(1, 7'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_done_cleared", bus1.image_done, 0);
    wait_drain(1);

    // M=0 last block: no beats, image_done next cycle, stays in IDLE
    send(1, 7'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("m0_done", bus1.image_done, 1);
    check("m0_ready", bus1.block_ready, 1);
    check("m0_valid", bus1.pix_valid, 0);
    check("m0_state", st1, IDLE);
    repeat (2) @(negedge clk);
    check("m0_no_beat", bus1.pix_valid, 0);

    // M above MAX_M clamps to MAX_M
    clear_block(1);
    for (int i = 0; i < MM * MM; i++) begin
      set_pix(1, i, 8'(i + 1));
      push1(8'(i + 1), (i == MM * MM - 1));
    end
    send(1, 7'd9, 1'b0, 1'b0);
    wait_drain(1);

    // 6: reset mid-stream at pixel 3 of a 4x4 block
    clear_block(1);
    for (int i = 0; i < 16; i++) set_pix(1, i, 8'(i + 1));
    push1(8'h01, 0); push1(8'h02, 0); push1(8'h03, 0);
    send(1, 7'd4, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_valid_in_reset", bus1.pix_valid, 0);
    check("t6_ready_in_reset", bus1.block_ready, 1);
    check("t6_keep_in_reset", bus1.pix_keep, 0);
    check("t6_state_in_reset", st1, IDLE);
    check("t6_beats_before_reset", exp_q1.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_beats_after_reset", bus1.pix_valid, 0);
    end
    check("t6_done_after_reset", bus1.image_done, 0);
    clear_block(1);
    set_pix(1, 0, 8'h5A);
    push1(8'h5A, 1);
    send(1, 7'd1, 1'b0, 1'b0);
    wait_drain(1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_pixel_streamer.md
Name: block_pixel_streamer

Overview:
- Generalised successor of the block-to-pixel serialiser in the watermark datapath.
- Accepts one watermarked M×M block per valid/ready handshake and streams its pixels downstream as LANES-pixel beats, in raster or column-major order, under full output backpressure.
- Flags end of image after the final beat of the block tagged last.
- Sits between the watermark-insertion core and the AMBA write-back path.

Parameters:
- DATA_DEPTH, 8, bits per pixel.
- MAX_M, 72, maximum block side length.
- LANES, 1, pixels per output beat (1, 2 or 4).
- IDX_W, derived as clog2(MAX_M*MAX_M+1), local; width of the pixel index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- m_size  in  7  block side M; sampled on block accept.
- mode  in  1  0 = raster (row-major), 1 = column-major; sampled on block accept.
- block_in  in  DATA_DEPTH*MAX_M*MAX_M  flat block; pixel (r,c) is at bits [(r*M+c)*DATA_DEPTH +: DATA_DEPTH].
- block_valid  in  1  block_in, m_size, mode and last_block are valid.
- block_ready  out  1  streamer can accept a block.
- last_block  in  1  this block is the last of the image; sampled on block accept.
- pix_data  out  LANES*DATA_DEPTH  output beat; lane 0 in the LSBs holds the earliest pixel.
- pix_keep  out  LANES  per-lane valid mask.
- pix_valid  out  1  beat valid.
- pix_ready  in  1  downstream accepts the beat.
- pix_last  out  1  final beat of the block.
- image_done  out  1  image complete; sticky.

Behaviour:
- Reset (rst=0, async): state IDLE, block_ready=1, pix_valid=0, pix_last=0, pix_keep=0, pix_data=0, image_done=0, counters=0. Reset mid-stream aborts the block; no further beats are issued.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - block_ready=1.
  - On block_valid&&block_ready: register block_in, M, mode and last_block; clear image_done.
  - Go to STREAM if M≥1. If M=0: no beats; image_done is set the next cycle if last_block=1, and the state stays IDLE.
  - M>MAX_M is clamped to MAX_M.
- STREAM:
  - block_ready=0.
  - First pix_valid is asserted the cycle after accept (latency 1).
  - A beat holds pix_data, pix_keep and pix_last stable while pix_valid&&!pix_ready.
  - On handshake the next beat is presented the following cycle with no bubble: one beat per cycle at pix_ready=1.
- Pixel ordering:
  - Raster: c inner, r outer.
  - Column-major: r inner, c outer; source index is always r*M+c.
  - Row and column counters wrap at M.
  - Lanes fill in order. The final beat carries rem = M*M mod LANES pixels (all LANES if rem=0); unused lanes have keep=0 and data=0.
- pix_last=1 only on the beat containing pixel M*M-1.
- DRAIN: entered on the pix_last handshake.
  - pix_valid=0.
  - image_done<=1 if the stored last flag is set.
  - Next cycle: IDLE, block_ready=1.
  - Minimum gap between blocks is 2 cycles after the final handshake.
- image_done stays high until the next block accept or reset.
- block_valid is ignored outside IDLE. The input block may change after accept, because the block is fully registered.
- All arithmetic is unsigned. The index product r*M+c is computed at IDX_W bits with no overflow for M≤MAX_M.

Decomposition:
- Shared package block_stream_pkg holds:
  - state encoding (IDLE/STREAM/DRAIN);
  - IDX_W, the clog2 function;
  - the MODE_RASTER and MODE_COLUMN constants.
- One sub-module, pixel_index_gen:
  - contains the row/column counters with wrap at M and the mode-dependent ordering;
  - emits LANES source indices per step;
  - asserts last_step when the final index is reached;
  - advances only on an advance strobe from the top FSM.

Test Plan:
1. M=2, mode=0, LANES=1, block pixels 0x11,0x22,0x33,0x44, pix_ready=1 -> beats 11,22,33,44 on 4 consecutive cycles starting 1 cycle after accept; pix_last only on 44.
2. Same block with mode=1 -> beats 11,33,22,44.
3. M=3, LANES=2, pixels 1..9 -> 5 beats: {2,1},{4,3},{6,5},{8,7},{0,9}; keep=11 on the first four, keep=01 with pix_last on the fifth.
4. M=2, pix_ready toggling 1,0,0,1 -> beat 22 held stable for 3 cycles until handshake; no pixel dropped or duplicated.
5. Block with last_block=1 -> image_done rises the cycle after the pix_last handshake and stays high; the next accept clears it; block_ready is 0 for the whole stream.
6. rst pulled low mid-stream at pixel 3 of M=4 -> pix_valid=0 and block_ready=1 immediately; after release a new M=1 block streams exactly one beat with pix_last=1.
